// File: rtl/lcd_req_arbiter_if.sv
// Requester-side handshake bundle for the shared character LCD: one byte offer per requester.
interface lcd_req_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   req_rs;
    logic [N_REQ-1:0]   req_nib;
    logic [8*N_REQ-1:0] req_data;

    modport master (
        output req_valid, req_rs, req_nib, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_rs, req_nib, req_data,
        output req_ready
    );
endinterface

// File: rtl/lcd_req_arbiter.sv
// Round-robin sharing of a 4-bit HD44780 LCD between N_REQ requesters, with nibble strobe
// timing and the controller execution wait generated from one down-counter.
//
// state   | meaning
// IDLE    | waiting for a requester; req_ready offered combinationally
// SETUP   | rs/data driven, e low, address setup time
// PULSE   | e high
// HOLD    | e low, data hold time; then low nibble or execution wait
// EXEC    | controller execution wait (short, or long for clear/home/nibble-only)
module lcd_req_arbiter #(
    parameter int CYCLES_PER_US = 50,
    parameter int N_REQ         = 2,
    parameter int EXEC_US       = 40,
    parameter int LONG_US       = 1640
) (
    input  logic               clk,
    input  logic               rst,
    lcd_req_arbiter_if.slave   req,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic [3:0]         lcd_data,
    output logic               lcd_e,
    output logic               lcd_rs,
    output logic               lcd_rw
);

    localparam int TW = $clog2(LONG_US*CYCLES_PER_US + 1);
    localparam logic [TW-1:0] T_STEP = TW'(CYCLES_PER_US - 1);
    localparam logic [TW-1:0] T_EXEC = TW'(EXEC_US*CYCLES_PER_US - 1);
    localparam logic [TW-1:0] T_LONG = TW'(LONG_US*CYCLES_PER_US - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_t;

    state_t           state, state_next;
    logic [TW-1:0]    cnt;
    logic [2:0]       rr;
    logic [7:0]       data_q;
    logic             rs_q;
    logic             nib_q;
    logic             nibble_hi;

    logic [N_REQ-1:0] ready_sel;
    logic [2:0]       win;
    logic             found;
    logic [7:0]       sel_data;
    logic             sel_rs;
    logic             sel_nib;
    logic             accept;
    logic             exec_long;
    logic             cnt_done;

    // Priority search starts one past the last winner and wraps modulo N_REQ.
    always_comb begin
        ready_sel = '0;
        win       = '0;
        found     = 1'b0;
        sel_data  = '0;
        sel_rs    = 1'b0;
        sel_nib   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && (i == (int'(rr) + k) % N_REQ) && req.req_valid[i]) begin
                    found        = 1'b1;
                    ready_sel[i] = 1'b1;
                    win          = 3'(i);
                    sel_data     = req.req_data[8*i +: 8];
                    sel_rs       = req.req_rs[i];
                    sel_nib      = req.req_nib[i];
                end
            end
        end
    end

    assign accept        = (state == S_IDLE) && found && !rst;
    assign req.req_ready = ((state == S_IDLE) && !rst) ? ready_sel : '0;
    assign lcd_rw        = 1'b0;
    assign cnt_done      = (cnt == '0);
    assign exec_long     = nib_q || (!rs_q && ((data_q == 8'h01) || (data_q == 8'h02)));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept)   state_next = S_SETUP;
            S_SETUP: if (cnt_done) state_next = S_PULSE;
            S_PULSE: if (cnt_done) state_next = S_HOLD;
            S_HOLD:  if (cnt_done) state_next = (nibble_hi && !nib_q) ? S_SETUP : S_EXEC;
            S_EXEC:  if (cnt_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rr        <= 3'(N_REQ - 1);
            data_q    <= '0;
            rs_q      <= 1'b0;
            nib_q     <= 1'b0;
            nibble_hi <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= '0;
            lcd_data  <= '0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
        end else begin
            state <= state_next;
            if (!cnt_done) cnt <= cnt - TW'(1);
            // Output registers are only touched on the edge that enters a new state.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        data_q    <= sel_data;
                        rs_q      <= sel_rs;
                        nib_q     <= sel_nib;
                        grant_id  <= win;
                        rr        <= win;
                        nibble_hi <= 1'b1;
                        lcd_data  <= sel_data[7:4];
                        lcd_rs    <= sel_rs;
                        busy      <= 1'b1;
                        cnt       <= T_STEP;
                    end
                end
                S_SETUP: begin
                    if (cnt_done) begin
                        lcd_e <= 1'b1;
                        cnt   <= T_STEP;
                    end
                end
                S_PULSE: begin
                    if (cnt_done) begin
                        lcd_e <= 1'b0;
                        cnt   <= T_STEP;
                    end
                end
                S_HOLD: begin
                    if (cnt_done) begin
                        if (nibble_hi && !nib_q) begin
                            nibble_hi <= 1'b0;
                            lcd_data  <= data_q[3:0];
                            cnt       <= T_STEP;
                        end else begin
                            cnt <= exec_long ? T_LONG : T_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_done) busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Directed bench for lcd_req_arbiter at CYCLES_PER_US=4, N_REQ=2, EXEC_US=40, LONG_US=1640.
module tb_lcd_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [2:0] grant_id;
    logic [3:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_req_arbiter_if #(.N_REQ(2)) bus();

    lcd_req_arbiter #(
        .CYCLES_PER_US(4),
        .N_REQ(2),
        .EXEC_US(40),
        .LONG_US(1640)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(bus.slave),
        .busy(busy),
        .grant_id(grant_id),
        .lcd_data(lcd_data),
        .lcd_e(lcd_e),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observes one transfer from the current (busy) sample until busy drops, bounded.
    task automatic measure(output int busy_cyc, output int pulses, output int e_cyc,
                           output logic [3:0] n1, output logic [3:0] n2,
                           output int ready_bad, output int unstable, output int rs_chg);
        logic       prev_e;
        logic [3:0] last_d;
        logic       rs0;
        busy_cyc = 0; pulses = 0; e_cyc = 0; n1 = 4'hx; n2 = 4'hx;
        ready_bad = 0; unstable = 0; rs_chg = 0;
        prev_e = 1'b0; last_d = lcd_data; rs0 = lcd_rs;
        while (busy === 1'b1 && busy_cyc < 8000) begin
            busy_cyc++;
            if (lcd_e === 1'b1) begin
                e_cyc++;
                if (!prev_e) begin
                    pulses++;
                    if (pulses == 1) n1 = lcd_data;
                    else if (pulses == 2) n2 = lcd_data;
                end else if (lcd_data !== last_d) begin
                    unstable++;
                end
            end
            if (bus.req_ready !== 2'b00) ready_bad++;
            if (lcd_rs !== rs0) rs_chg++;
            prev_e = lcd_e;
            last_d = lcd_data;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11; bus.req_rs = 2'b00; bus.req_nib = 2'b00; bus.req_data = 16'h0000;
        step(); step();
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++;
        if (lcd_e !== 1'b0) begin errors++; $display("FAIL reset_lcd_e got=%0b exp=0", lcd_e); end
        checks++;
        if (lcd_data !== 4'h0) begin errors++; $display("FAIL reset_lcd_data got=%h exp=0", lcd_data); end
        checks++;
        if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_lcd_rs got=%0b exp=0", lcd_rs); end
        checks++;
        if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_lcd_rw got=%0b exp=0", lcd_rw); end
        checks++;
        if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        checks++;
        if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
        checks++;
        bus.req_valid = 2'b00;
        rst = 1'b0;
        step();
        if (busy !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle busy=%0b ready=%b exp busy=0 ready=00", busy, bus.req_ready);
        end
        checks++;
    endtask

    task automatic test_single_byte();
        int bc, pc, ec, rb, us, rc;
        logic [3:0] a, b;
        bus.req_data = 16'h0048; bus.req_rs = 2'b01; bus.req_nib = 2'b00; bus.req_valid = 2'b01;
        #1;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
        checks++;
        step();
        bus.req_valid = 2'b00;
        if (busy !== 1'b1 || lcd_data !== 4'h4 || lcd_rs !== 1'b1 || lcd_e !== 1'b0 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL single_accept busy=%0b data=%h rs=%0b e=%0b gid=%0d exp 1 4 1 0 0",
                     busy, lcd_data, lcd_rs, lcd_e, grant_id);
        end
        checks++;
        measure(bc, pc, ec, a, b, rb, us, rc);
        if (bc != 184) begin errors++; $display("FAIL single_busy_cycles got=%0d exp=184", bc); end
        checks++;
        if (pc != 2 || ec != 8) begin errors++; $display("FAIL single_pulses got=%0d/%0d exp=2/8", pc, ec); end
        checks++;
        if (a !== 4'h4 || b !== 4'h8) begin errors++; $display("FAIL single_nibbles got=%h,%h exp=4,8", a, b); end
        checks++;
        if (rb != 0 || us != 0 || rc != 0) begin
            errors++; $display("FAIL single_stability ready_bad=%0d unstable=%0d rs_chg=%0d exp=0", rb, us, rc);
        end
        checks++;
    endtask

    task automatic test_fairness();
        int bc, pc, ec, rb, us, rc;
        logic [3:0] a, b;
        logic [1:0] exp_ready;
        rst = 1'b1;
        bus.req_data = 16'h4241; bus.req_rs = 2'b11; bus.req_nib = 2'b00; bus.req_valid = 2'b11;
        step(); step();
        if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL fair_ready_in_reset got=%b exp=00", bus.req_ready); end
        checks++;
        rst = 1'b0;
        #1;
        for (int t = 0; t < 4; t++) begin
            exp_ready = (t % 2 == 0) ? 2'b01 : 2'b10;
            if (bus.req_ready !== exp_ready) begin
                errors++; $display("FAIL fair_ready[%0d] got=%b exp=%b", t, bus.req_ready, exp_ready);
            end
            checks++;
            step();
            if (grant_id !== 3'(t % 2) || busy !== 1'b1) begin
                errors++; $display("FAIL fair_grant[%0d] gid=%0d busy=%0b exp gid=%0d busy=1", t, grant_id, busy, t % 2);
            end
            checks++;
            if (t == 3) bus.req_valid = 2'b00;
            measure(bc, pc, ec, a, b, rb, us, rc);
            if (bc != 184 || rb != 0) begin
                errors++; $display("FAIL fair_xfer[%0d] busy=%0d ready_bad=%0d exp 184/0", t, bc, rb);
            end
            checks++;
        end
    endtask

    task automatic test_clear_cmd();
        int bc, pc, ec, rb, us, rc;
        logic [3:0] a, b;
        bus.req_data = 16'h0141; bus.req_rs = 2'b01; bus.req_nib = 2'b00; bus.req_valid = 2'b10;
        #1;
        if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL clear_ready got=%b exp=10", bus.req_ready); end
        checks++;
        step();
        bus.req_valid = 2'b01;
        if (grant_id !== 3'd1 || lcd_data !== 4'h0 || lcd_rs !== 1'b0) begin
            errors++; $display("FAIL clear_accept gid=%0d data=%h rs=%0b exp 1 0 0", grant_id, lcd_data, lcd_rs);
        end
        checks++;
        measure(bc, pc, ec, a, b, rb, us, rc);
        if (bc != 6584) begin errors++; $display("FAIL clear_busy_cycles got=%0d exp=6584", bc); end
        checks++;
        if (pc != 2 || a !== 4'h0 || b !== 4'h1) begin
            errors++; $display("FAIL clear_nibbles pulses=%0d got=%h,%h exp 2 0,1", pc, a, b);
        end
        checks++;
        if (rb != 0) begin errors++; $display("FAIL clear_ready_while_busy got=%0d exp=0", rb); end
        checks++;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL clear_next_ready got=%b exp=01", bus.req_ready); end
        checks++;
        step();
        bus.req_valid = 2'b00;
        if (grant_id !== 3'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL clear_next_accept gid=%0d busy=%0b exp 0 1", grant_id, busy);
        end
        checks++;
        measure(bc, pc, ec, a, b, rb, us, rc);
        if (bc != 184) begin errors++; $display("FAIL clear_next_busy got=%0d exp=184", bc); end
        checks++;
    endtask

    task automatic test_nibble_only();
        int bc, pc, ec, rb, us, rc;
        logic [3:0] a, b;
        bus.req_data = 16'h0030; bus.req_rs = 2'b00; bus.req_nib = 2'b01; bus.req_valid = 2'b01;
        #1;
        step();
        bus.req_valid = 2'b00;
        if (busy !== 1'b1 || lcd_data !== 4'h3) begin
            errors++; $display("FAIL nib_accept busy=%0b data=%h exp 1 3", busy, lcd_data);
        end
        checks++;
        measure(bc, pc, ec, a, b, rb, us, rc);
        if (bc != 6572) begin errors++; $display("FAIL nib_busy_cycles got=%0d exp=6572", bc); end
        checks++;
        if (pc != 1 || ec != 4 || a !== 4'h3) begin
            errors++; $display("FAIL nib_pulse pulses=%0d e_cyc=%0d data=%h exp 1 4 3", pc, ec, a);
        end
        checks++;
        bus.req_nib = 2'b00;
    endtask

    task automatic test_reset_mid_pulse();
        int bc, pc, ec, rb, us, rc, n;
        logic [3:0] a, b;
        bus.req_data = 16'h0048; bus.req_rs = 2'b01; bus.req_valid = 2'b01;
        #1;
        step();
        n = 0;
        while (lcd_e !== 1'b1 && n < 20) begin step(); n++; end
        if (lcd_e !== 1'b1) begin errors++; $display("FAIL rstmid_pulse_seen got=%0b exp=1", lcd_e); end
        checks++;
        rst = 1'b1;
        step();
        if (lcd_e !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL rstmid_abort e=%0b busy=%0b ready=%b exp 0 0 00", lcd_e, busy, bus.req_ready);
        end
        checks++;
        rst = 1'b0;
        #1;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_reready got=%b exp=01", bus.req_ready); end
        checks++;
        step();
        bus.req_valid = 2'b00;
        if (busy !== 1'b1 || lcd_data !== 4'h4 || grant_id !== 3'd0) begin
            errors++; $display("FAIL rstmid_reaccept busy=%0b data=%h gid=%0d exp 1 4 0", busy, lcd_data, grant_id);
        end
        checks++;
        measure(bc, pc, ec, a, b, rb, us, rc);
        if (bc != 184 || pc != 2) begin errors++; $display("FAIL rstmid_xfer busy=%0d pulses=%0d exp 184 2", bc, pc); end
        checks++;
    endtask

    task automatic test_drop_while_busy();
        int bc, pc, ec, rb, us, rc, act;
        logic [3:0] a, b;
        bus.req_data = 16'h4200; bus.req_rs = 2'b10; bus.req_valid = 2'b10;
        #1;
        step();
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        measure(bc, pc, ec, a, b, rb, us, rc);
        if (bc != 183 || rb != 0) begin
            errors++; $display("FAIL drop_xfer busy=%0d ready_bad=%0d exp 183 0", bc, rb);
        end
        checks++;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            if (lcd_e !== 1'b0 || busy !== 1'b0) act++;
            step();
        end
        if (act != 0) begin errors++; $display("FAIL drop_no_activity got=%0d exp=0", act); end
        checks++;
        if (grant_id !== 3'd1) begin errors++; $display("FAIL drop_grant_id got=%0d exp=1", grant_id); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fairness();
        test_clear_cmd();
        test_nibble_only();
        test_reset_mid_pulse();
        test_drop_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
